decode_ctrl_hazard: RTL and testbench

- Decode-stage control for the 5-stage MIPS-like pipeline, merging three functions:
  - instruction decode into datapath selects, ALU and branch opcodes;
  - immediate/shamt extension to 32 bits;
  - load-use stall detection and E/M/W result forwarding onto the two register-read operands.
- Sits between the register file and the DEC/EXE pipeline register.
- Keeps a private 3-deep history of issued destination registers, so no downstream WRA/regWe feedback is needed.

---
 rtl/decode_ctrl_hazard_pkg.sv | 70 +++++++
 rtl/decode_ctrl_hazard_hazard_fwd_unit.sv | 72 +++++++
 rtl/decode_ctrl_hazard.sv | 138 +++++++++++++
 tb/tb_decode_ctrl_hazard.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_ctrl_hazard_pkg.sv
// rtl/decode_ctrl_hazard_pkg.sv - opcode/funct constants, ALU and branch op encodings
package decode_ctrl_hazard_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_XORI   = 6'h0e;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,  ALU_SUB = 5'd1,  ALU_AND = 5'd2,  ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,  ALU_NOR = 5'd5,  ALU_SLT = 5'd6,  ALU_SLTU = 5'd7,
        ALU_SLL  = 5'd8,  ALU_SRL = 5'd9,  ALU_SRA = 5'd10, ALU_LUI  = 5'd11,
        ALU_LINK = 5'd12
    } alu_op_e;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0, BR_BEQ = 4'd1, BR_BNE = 4'd2, BR_BLEZ = 4'd3,
        BR_BGTZ = 4'd4, BR_BLTZ = 4'd5, BR_BGEZ = 4'd6, BR_J = 4'd7,
        BR_JAL  = 4'd8, BR_JR = 4'd9, BR_JALR = 4'd10
    } br_op_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] wra;
    } hist_slot_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'b0, v};
    endfunction

endpackage

// File: rtl/decode_ctrl_hazard_hazard_fwd_unit.sv
// rtl/decode_ctrl_hazard_hazard_fwd_unit.sv - issued-destination history, E/M/W forwarding and load-use stall
module hazard_fwd_unit
    import decode_ctrl_hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic        i_use_rs,
    input  logic        i_use_rt,
    input  logic        i_we,
    input  logic [4:0]  i_wra,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_rd1,
    input  logic [31:0] i_rd2,
    input  logic [31:0] i_alu_out_e,
    input  logic [31:0] i_mem_m,
    input  logic [31:0] i_rst_w,
    output logic        o_pause,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);

    hist_slot_t slot_e_q, slot_e_d, slot_m_q, slot_m_d, slot_w_q, slot_w_d;
    logic       load_e_q, load_e_d;

    // A matching load in E falls through to older slots; the stall hides that value.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf,
                                        input hist_slot_t e, input logic e_load,
                                        input hist_slot_t m, input hist_slot_t w,
                                        input logic [31:0] ve, input logic [31:0] vm,
                                        input logic [31:0] vw);
        if (src == 5'd0)                        return rf;
        if (e.valid && e.wra == src && !e_load) return ve;
        if (m.valid && m.wra == src)            return vm;
        if (w.valid && w.wra == src)            return vw;
        return rf;
    endfunction

    always_comb begin
        o_pause = slot_e_q.valid && load_e_q && (slot_e_q.wra != 5'd0) &&
                  ((i_use_rs && slot_e_q.wra == i_rs) || (i_use_rt && slot_e_q.wra == i_rt));
        o_rd1 = fwd(i_rs, i_rd1, slot_e_q, load_e_q, slot_m_q, slot_w_q,
                    i_alu_out_e, i_mem_m, i_rst_w);
        o_rd2 = fwd(i_rt, i_rd2, slot_e_q, load_e_q, slot_m_q, slot_w_q,
                    i_alu_out_e, i_mem_m, i_rst_w);
    end

    always_comb begin
        slot_w_d       = slot_m_q;
        slot_m_d       = slot_e_q;
        slot_e_d.valid = i_we && !o_pause && !i_flush;
        slot_e_d.wra   = i_wra;
        load_e_d       = i_load;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_e_q <= '0;
            slot_m_q <= '0;
            slot_w_q <= '0;
            load_e_q <= 1'b0;
        end else begin
            slot_e_q <= slot_e_d;
            slot_m_q <= slot_m_d;
            slot_w_q <= slot_w_d;
            load_e_q <= load_e_d;
        end
    end

endmodule

// File: rtl/decode_ctrl_hazard.sv
// rtl/decode_ctrl_hazard.sv - decode-stage control: instruction decode, immediate extension, hazard/forwarding
module decode_ctrl_hazard
    import decode_ctrl_hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_inst,
    input  logic        i_flush,
    input  logic [31:0] i_rd1,
    input  logic [31:0] i_rd2,
    input  logic [31:0] i_aluOutE,
    input  logic [31:0] i_dMemRDataM,
    input  logic [31:0] i_rstW,
    output logic        o_regWe,
    output logic        o_dMemWe,
    output logic        o_sWRD,
    output logic        o_sA0,
    output logic        o_sA,
    output logic        o_sB,
    output logic        o_sByte,
    output logic [4:0]  o_aluOP,
    output logic [3:0]  o_brOP,
    output logic [4:0]  o_WRA,
    output logic [31:0] o_num,
    output logic        o_pause,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd, f_sa;
    logic [15:0] imm;
    logic       dec_we, dec_dmem_we, dec_load, use_rs, use_rt;
    alu_op_e    dec_alu;
    br_op_e     dec_br;

    assign op    = i_inst[31:26];
    assign rs    = i_inst[25:21];
    assign rt    = i_inst[20:16];
    assign rd    = i_inst[15:11];
    assign f_sa  = i_inst[10:6];
    assign funct = i_inst[5:0];
    assign imm   = i_inst[15:0];

    always_comb begin
        dec_we = 1'b0; dec_dmem_we = 1'b0; dec_load = 1'b0;
        o_sWRD = 1'b0; o_sA0 = 1'b0; o_sA = 1'b0; o_sB = 1'b0; o_sByte = 1'b0;
        dec_alu = ALU_ADD; dec_br = BR_NONE; o_WRA = 5'd0; o_num = 32'd0;
        use_rs = (op != OP_J) && (op != OP_JAL);
        use_rt = 1'b0;
        case (op)
            OP_RTYPE: begin
                use_rt = 1'b1;
                dec_we = 1'b1;
                o_WRA  = rd;
                case (funct)
                    FN_ADD, FN_ADDU: dec_alu = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_alu = ALU_SUB;
                    FN_AND:  dec_alu = ALU_AND;
                    FN_OR:   dec_alu = ALU_OR;
                    FN_XOR:  dec_alu = ALU_XOR;
                    FN_NOR:  dec_alu = ALU_NOR;
                    FN_SLT:  dec_alu = ALU_SLT;
                    FN_SLTU: dec_alu = ALU_SLTU;
                    FN_SLL:  begin dec_alu = ALU_SLL; o_sA = 1'b1; o_num = {27'b0, f_sa}; end
                    FN_SRL:  begin dec_alu = ALU_SRL; o_sA = 1'b1; o_num = {27'b0, f_sa}; end
                    FN_SRA:  begin dec_alu = ALU_SRA; o_sA = 1'b1; o_num = {27'b0, f_sa}; end
                    FN_SLLV: dec_alu = ALU_SLL;
                    FN_SRLV: dec_alu = ALU_SRL;
                    FN_SRAV: dec_alu = ALU_SRA;
                    FN_JR:   begin dec_br = BR_JR; dec_we = 1'b0; end
                    FN_JALR: begin dec_br = BR_JALR; o_sA0 = 1'b1; dec_alu = ALU_LINK; end
                    default: begin dec_we = 1'b0; o_WRA = 5'd0; end
                endcase
            end
            OP_REGIMM: begin
                if (rt == 5'd0)      begin dec_br = BR_BLTZ; o_num = sext16(imm); end
                else if (rt == 5'd1) begin dec_br = BR_BGEZ; o_num = sext16(imm); end
            end
            OP_J:    dec_br = BR_J;
            OP_JAL:  begin dec_br = BR_JAL; o_sA0 = 1'b1; dec_alu = ALU_LINK; o_WRA = 5'd31; dec_we = 1'b1; end
            OP_BEQ:  begin dec_br = BR_BEQ;  o_num = sext16(imm); use_rt = 1'b1; end
            OP_BNE:  begin dec_br = BR_BNE;  o_num = sext16(imm); use_rt = 1'b1; end
            OP_BLEZ: begin dec_br = BR_BLEZ; o_num = sext16(imm); end
            OP_BGTZ: begin dec_br = BR_BGTZ; o_num = sext16(imm); end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec_we = 1'b1; o_WRA = rt; o_sB = 1'b1;
                o_num  = (op inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI}) ? zext16(imm) : sext16(imm);
                case (op)
                    OP_SLTI:  dec_alu = ALU_SLT;
                    OP_SLTIU: dec_alu = ALU_SLTU;
                    OP_ANDI:  dec_alu = ALU_AND;
                    OP_ORI:   dec_alu = ALU_OR;
                    OP_XORI:  dec_alu = ALU_XOR;
                    OP_LUI:   dec_alu = ALU_LUI;
                    default:  dec_alu = ALU_ADD;
                endcase
            end
            OP_LB, OP_LW: begin
                dec_we = 1'b1; o_WRA = rt; o_sB = 1'b1; o_sWRD = 1'b1; dec_load = 1'b1;
                o_num = sext16(imm); o_sByte = (op == OP_LB);
            end
            OP_SB, OP_SW: begin
                dec_dmem_we = 1'b1; o_sB = 1'b1; use_rt = 1'b1;
                o_num = sext16(imm); o_sByte = (op == OP_SB);
            end
            default: use_rs = 1'b1;
        endcase
    end

    // A stalled instruction must not commit anything when E captures it as a bubble.
    assign o_regWe  = dec_we && (o_WRA != 5'd0) && !o_pause;
    assign o_dMemWe = dec_dmem_we && !o_pause;
    assign o_brOP   = o_pause ? BR_NONE : dec_br;
    assign o_aluOP  = dec_alu;

    hazard_fwd_unit u_hazard (
        .clk         (clk),
        .rstn        (rstn),
        .i_rs        (rs),
        .i_rt        (rt),
        .i_use_rs    (use_rs),
        .i_use_rt    (use_rt),
        .i_we        (dec_we && (o_WRA != 5'd0)),
        .i_wra       (o_WRA),
        .i_load      (dec_load),
        .i_flush     (i_flush),
        .i_rd1       (i_rd1),
        .i_rd2       (i_rd2),
        .i_alu_out_e (i_aluOutE),
        .i_mem_m     (i_dMemRDataM),
        .i_rst_w     (i_rstW),
        .o_pause     (o_pause),
        .o_rd1       (o_rd1),
        .o_rd2       (o_rd2)
    );

endmodule

// File: tb/tb_decode_ctrl_hazard.sv
// tb/tb_decode_ctrl_hazard.sv - scoreboard bench for decode_ctrl_hazard with a behavioural reference model
module tb_decode_ctrl_hazard;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] i_inst = '0, i_rd1 = '0, i_rd2 = '0, i_aluOutE = '0, i_dMemRDataM = '0, i_rstW = '0;
    logic        i_flush = 1'b0;
    logic        o_regWe, o_dMemWe, o_sWRD, o_sA0, o_sA, o_sB, o_sByte, o_pause;
    logic [4:0]  o_aluOP, o_WRA;
    logic [3:0]  o_brOP;
    logic [31:0] o_num, o_rd1, o_rd2;

    always #5 clk = ~clk;

    decode_ctrl_hazard dut (
        .clk(clk), .rstn(rstn), .i_inst(i_inst), .i_flush(i_flush),
        .i_rd1(i_rd1), .i_rd2(i_rd2), .i_aluOutE(i_aluOutE),
        .i_dMemRDataM(i_dMemRDataM), .i_rstW(i_rstW),
        .o_regWe(o_regWe), .o_dMemWe(o_dMemWe), .o_sWRD(o_sWRD), .o_sA0(o_sA0),
        .o_sA(o_sA), .o_sB(o_sB), .o_sByte(o_sByte), .o_aluOP(o_aluOP),
        .o_brOP(o_brOP), .o_WRA(o_WRA), .o_num(o_num), .o_pause(o_pause),
        .o_rd1(o_rd1), .o_rd2(o_rd2)
    );

    typedef struct {
        bit we, dwe, swrd, sa0, sa, sb, sbyte, ld, urs, urt;
        bit [4:0] alu, wra;
        bit [3:0] br;
        bit [31:0] num;
    } dec_t;
    typedef struct { bit v; bit [4:0] wra; bit ld; } slot_t;
    typedef struct {
        logic [63:0] ctl;
        logic [31:0] rd1, rd2;
        bit c1, c2, pause;
    } exp_t;

    slot_t hist[$];
    slot_t pending;
    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;

    bit [5:0] op_tab [0:22] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                                6'h07, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                                6'h20, 6'h23, 6'h28, 6'h2b, 6'h3f};
    bit [5:0] fn_tab [0:18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h20,
                                6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h3f};

    function automatic int r_alu(input bit [5:0] fn);
        case (fn)
            6'h20, 6'h21: return 0;  6'h22, 6'h23: return 1;
            6'h24: return 2;  6'h25: return 3;  6'h26: return 4;  6'h27: return 5;
            6'h2a: return 6;  6'h2b: return 7;
            6'h00, 6'h04: return 8;  6'h02, 6'h06: return 9;  6'h03, 6'h07: return 10;
            default: return -1;
        endcase
    endfunction

    function automatic int i_alu(input bit [5:0] op);
        case (op)
            6'h08, 6'h09: return 0;  6'h0a: return 6;  6'h0b: return 7;
            6'h0c: return 2;  6'h0d: return 3;  6'h0e: return 4;  6'h0f: return 11;
            default: return -1;
        endcase
    endfunction

    function automatic dec_t ref_decode(input bit [31:0] ins);
        dec_t d;
        bit [5:0] op = ins[31:26];
        bit [5:0] fn = ins[5:0];
        bit [31:0] se = {{16{ins[15]}}, ins[15:0]};
        bit [31:0] ze = {16'h0, ins[15:0]};
        d = '{default: 0};
        d.urs = (op != 6'h02) && (op != 6'h03);
        if (op == 6'h00) begin
            d.urt = 1;
            if (r_alu(fn) >= 0) begin
                d.we = 1; d.wra = ins[15:11]; d.alu = 5'(r_alu(fn));
                if (fn < 6'h04) begin d.sa = 1; d.num = {27'h0, ins[10:6]}; end
            end else if (fn == 6'h08) begin
                d.br = 9; d.wra = ins[15:11];
            end else if (fn == 6'h09) begin
                d.br = 10; d.sa0 = 1; d.alu = 12; d.we = 1; d.wra = ins[15:11];
            end
        end else if (i_alu(op) >= 0) begin
            d.we = 1; d.wra = ins[20:16]; d.sb = 1; d.alu = 5'(i_alu(op));
            d.num = (op >= 6'h0c) ? ze : se;
        end else if (op == 6'h20 || op == 6'h23) begin
            d.we = 1; d.wra = ins[20:16]; d.sb = 1; d.swrd = 1; d.ld = 1;
            d.num = se; d.sbyte = (op == 6'h20);
        end else if (op == 6'h28 || op == 6'h2b) begin
            d.dwe = 1; d.sb = 1; d.num = se; d.sbyte = (op == 6'h28); d.urt = 1;
        end else if (op >= 6'h04 && op <= 6'h07) begin
            d.br = 4'(op - 6'h03); d.num = se; d.urt = (op <= 6'h05);
        end else if (op == 6'h01 && ins[20:16] <= 5'd1) begin
            d.br = 4'(5 + ins[16]); d.num = se;
        end else if (op == 6'h02) begin
            d.br = 7;
        end else if (op == 6'h03) begin
            d.br = 8; d.sa0 = 1; d.alu = 12; d.wra = 31; d.we = 1;
        end
        return d;
    endfunction

    task automatic model_fwd(input bit [4:0] r, input bit [31:0] rf, input bit [31:0] vals [3],
                             output bit [31:0] v, output bit ok);
        ok = 1; v = rf;
        if (r == 0) return;
        for (int k = 0; k < 3; k++) begin
            if (hist[k].v && hist[k].wra == r) begin
                if (k == 0 && hist[0].ld) ok = 0;
                else v = vals[k];
                return;
            end
        end
    endtask

    task automatic clear_hist();
        hist = {};
        repeat (3) hist.push_back('{v: 0, wra: 0, ld: 0});
    endtask

    task automatic issue(input bit [31:0] ins, input bit fl = 0, input bit rst_now = 0);
        dec_t d;
        exp_t e;
        bit [31:0] vals [3];
        bit pause;
        @(posedge clk);
        if (rstn) begin
            hist.push_front(pending);
            void'(hist.pop_back());
        end
        #1;
        if (rst_now) begin rstn = 1'b0; clear_hist(); end
        else rstn = 1'b1;
        i_inst = ins; i_flush = fl;
        i_rd1 = $urandom; i_rd2 = $urandom;
        i_aluOutE = $urandom; i_dMemRDataM = $urandom; i_rstW = $urandom;
        vals = '{i_aluOutE, i_dMemRDataM, i_rstW};
        d = ref_decode(ins);
        pause = hist[0].v && hist[0].ld && hist[0].wra != 0 &&
                ((d.urs && hist[0].wra == ins[25:21]) || (d.urt && hist[0].wra == ins[20:16]));
        e.pause = pause;
        e.ctl = 64'({d.we && d.wra != 0 && !pause, d.dwe && !pause, d.swrd, d.sa0, d.sa, d.sb,
                     d.sbyte, d.alu, pause ? 4'd0 : d.br, d.wra, d.num});
        model_fwd(ins[25:21], i_rd1, vals, e.rd1, e.c1);
        model_fwd(ins[20:16], i_rd2, vals, e.rd2, e.c2);
        e.c1 = e.c1 && !pause;
        e.c2 = e.c2 && !pause;
        exp_q.push_back(e);
        pending = '{v: d.we && d.wra != 0 && !pause && !fl && !rst_now, wra: d.wra, ld: d.ld};
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h inst=%h", nm, act, req, i_inst);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ctrl", 64'({o_regWe, o_dMemWe, o_sWRD, o_sA0, o_sA, o_sB, o_sByte,
                                 o_aluOP, o_brOP, o_WRA, o_num}), e.ctl);
                chk("pause", 64'(o_pause), 64'(e.pause));
                if (e.c1) chk("rd1", 64'(o_rd1), 64'(e.rd1));
                if (e.c2) chk("rd2", 64'(o_rd2), 64'(e.rd2));
            end
        end
    end

    function automatic bit [31:0] rand_inst();
        bit [31:0] ins;
        ins = $urandom;
        ins[31:26] = op_tab[$urandom_range(0, 22)];
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        ins[15:11] = 5'($urandom_range(0, 7));
        if (ins[31:26] == 6'h00) ins[5:0] = fn_tab[$urandom_range(0, 18)];
        if (ins[31:26] == 6'h01) ins[20:16] = 5'($urandom_range(0, 2));
        return ins;
    endfunction

    initial begin
        clear_hist();
        pending = '{v: 0, wra: 0, ld: 0};
        repeat (2) @(posedge clk);
        issue(32'h00222020, 0, 1);   // reader in reset: pass-through
        issue(32'h2001FFFF);         // ADDI $1,$0,-1
        issue(32'h34028000);         // ORI  $2,$0,0x8000
        issue(32'h00021900);         // SLL  $3,$2,4
        issue(32'h00222020);         // ADD  $4,$1,$2
        issue(32'h00842822);         // SUB  $5,$4,$4  (E)
        issue(32'h00804025);         // OR   $8,$4,$0  (M)
        issue(32'h00804025);         // OR   $8,$4,$0  (W)
        issue(32'h8C260000);         // LW   $6,0($1)
        issue(32'h00C03820);         // ADD  $7,$6,$0  stalled
        issue(32'h00C03820);         // ADD  $7,$6,$0  from M
        issue(32'h20200005);         // ADDI $0,$1,5
        issue(32'h00004820);         // ADD  $9,$0,$0
        issue(32'h0C000010);         // JAL
        issue(32'h00225020, 1);      // ADD  $10 flushed
        issue(32'h014A5820);         // ADD  $11,$10,$10
        issue(32'h00222020);         // ADD  $4,$1,$2
        issue(32'h00842822, 0, 1);   // reset mid-stream drops $4
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) issue(rand_inst(), 0, 1);
            else issue(rand_inst(), ($urandom_range(0, 9) == 0));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
